// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and default sizes for the snake body tracer
package snake_pkg;

    localparam int DEF_WIDTH  = 2;
    localparam int DEF_DEPTH  = 234;
    localparam int DEF_GRID_W = 18;
    localparam int DEF_GRID_H = 13;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_WAIT,
        ST_TRACE_WAIT,
        ST_TRACE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/snake_body_tracer_if.sv
// rtl/snake_body_tracer_if.sv - push/trace request and result bundle between game logic and tracer
interface snake_body_tracer_if #(
    parameter int WIDTH = 2,
    parameter int X_W   = 5,
    parameter int Y_W   = 4,
    parameter int LEN_W = 8
);
    logic             push_valid;
    logic [WIDTH-1:0] push_dir;
    logic             push_ready;
    logic             trace_valid;
    logic             trace_ready;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;
    logic [LEN_W-1:0] length;
    logic [X_W-1:0]   query_x;
    logic [Y_W-1:0]   query_y;
    logic             busy;
    logic             done;
    logic             hit;
    logic [LEN_W-1:0] hit_index;
    logic [X_W-1:0]   tail_x;
    logic [Y_W-1:0]   tail_y;

    modport master (
        output push_valid, push_dir, trace_valid, head_x, head_y, length, query_x, query_y,
        input  push_ready, trace_ready, busy, done, hit, hit_index, tail_x, tail_y
    );

    modport slave (
        input  push_valid, push_dir, trace_valid, head_x, head_y, length, query_x, query_y,
        output push_ready, trace_ready, busy, done, hit, hit_index, tail_x, tail_y
    );
endinterface

// File: rtl/snake_step.sv
// rtl/snake_step.sv - wrap-around reverse step: position of the segment behind a move
module snake_step
    import snake_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int X_W    = 5,
    parameter int Y_W    = 4
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  dir_t           dir,
    output logic [X_W-1:0] prev_x,
    output logic [Y_W-1:0] prev_y
);
    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    // Undo the move: subtract the direction's delta, wrapping at the grid edges.
    always_comb begin
        prev_x = x;
        prev_y = y;
        case (dir)
            DIR_RIGHT: prev_x = (x == '0)     ? X_LAST : x - X_W'(1);
            DIR_LEFT:  prev_x = (x == X_LAST) ? '0     : x + X_W'(1);
            DIR_DOWN:  prev_y = (y == '0)     ? Y_LAST : y - Y_W'(1);
            DIR_UP:    prev_y = (y == Y_LAST) ? '0     : y + Y_W'(1);
        endcase
    end
endmodule

// File: rtl/snake_body_tracer.sv
// rtl/snake_body_tracer.sv - ring recirculation, head insertion and body walk over the direction ring
module snake_body_tracer
    import snake_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int X_W    = 5,
    parameter int Y_W    = 4,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sr_out,
    output logic [WIDTH-1:0] sr_in,
    snake_body_tracer_if.slave bus
);
    localparam int              PH_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEPTH - 1);

    state_t           state, state_nx;
    logic [PH_W-1:0]  phase, phase_nx, head_phase, push_phase;
    logic [WIDTH-1:0] dir_q;
    logic [X_W-1:0]   pos_x, query_x_q, tail_x_q, step_x;
    logic [Y_W-1:0]   pos_y, query_y_q, tail_y_q, step_y;
    logic [LEN_W-1:0] len_q, k, len_eff, hit_index_q;
    logic             hit_q, last_step;

    assign phase_nx   = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    assign push_phase = (head_phase == '0) ? PH_LAST : head_phase - PH_W'(1);
    assign last_step  = (k == len_q - LEN_W'(1));

    always_comb begin
        if (bus.length == '0)
            len_eff = LEN_W'(1);
        else if (bus.length > LEN_W'(DEPTH))
            len_eff = LEN_W'(DEPTH);
        else
            len_eff = bus.length;
    end

    snake_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_step (
        .x      (pos_x),
        .y      (pos_y),
        .dir    (dir_t'(sr_out)),
        .prev_x (step_x),
        .prev_y (step_y)
    );

    // Trace waits land one cycle early so TRACE's first cycle is the one where d_1 is on sr_out.
    always_comb begin
        state_nx        = state;
        sr_in           = sr_out;
        bus.push_ready  = 1'b0;
        bus.trace_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    bus.push_ready  = bus.push_valid;
                    bus.trace_ready = bus.trace_valid & ~bus.push_valid;
                end
                if (bus.push_valid)
                    state_nx = ST_PUSH_WAIT;
                else if (bus.trace_valid) begin
                    if (len_eff == LEN_W'(1))
                        state_nx = ST_DONE;
                    else if (phase_nx == head_phase)
                        state_nx = ST_TRACE;
                    else
                        state_nx = ST_TRACE_WAIT;
                end
            end
            ST_PUSH_WAIT: begin
                if (phase == push_phase) begin
                    if (!rst)
                        sr_in = dir_q;
                    state_nx = ST_IDLE;
                end
            end
            ST_TRACE_WAIT: if (phase_nx == head_phase) state_nx = ST_TRACE;
            ST_TRACE:      if (last_step) state_nx = ST_DONE;
            ST_DONE:       state_nx = ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= '0;
            head_phase  <= '0;
            dir_q       <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            query_x_q   <= '0;
            query_y_q   <= '0;
            len_q       <= '0;
            k           <= '0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
            tail_x_q    <= '0;
            tail_y_q    <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            case (state)
                ST_IDLE: begin
                    if (bus.push_valid)
                        dir_q <= bus.push_dir;
                    else if (bus.trace_valid) begin
                        pos_x       <= bus.head_x;
                        pos_y       <= bus.head_y;
                        query_x_q   <= bus.query_x;
                        query_y_q   <= bus.query_y;
                        len_q       <= len_eff;
                        k           <= LEN_W'(1);
                        hit_q       <= 1'b0;
                        hit_index_q <= '0;
                        if (len_eff == LEN_W'(1)) begin
                            tail_x_q <= bus.head_x;
                            tail_y_q <= bus.head_y;
                        end
                    end
                end
                ST_PUSH_WAIT: if (phase == push_phase) head_phase <= phase;
                ST_TRACE: begin
                    pos_x <= step_x;
                    pos_y <= step_y;
                    k     <= k + LEN_W'(1);
                    if (step_x == query_x_q && step_y == query_y_q && !hit_q) begin
                        hit_q       <= 1'b1;
                        hit_index_q <= k;
                    end
                    if (last_step) begin
                        tail_x_q <= step_x;
                        tail_y_q <= step_y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.hit       = hit_q;
    assign bus.hit_index = hit_index_q;
    assign bus.tail_x    = tail_x_q;
    assign bus.tail_y    = tail_y_q;
endmodule

// File: tb/tb_snake_body_tracer.sv
// tb/tb_snake_body_tracer.sv - directed bench for snake_body_tracer with DEPTH=8 and default-DEPTH instances
module tb_snake_body_tracer;
    import snake_pkg::*;

    localparam int D     = 8;
    localparam int DB    = 234;
    localparam int X_W   = 5;
    localparam int Y_W   = 4;
    localparam int LEN_S = 4;
    localparam int LEN_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ring_clr = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    snake_body_tracer_if #(.WIDTH(2), .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_S)) bs ();
    snake_body_tracer_if #(.WIDTH(2), .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_B)) bb ();

    logic [1:0] sr_in_s, sr_out_s, sr_in_b, sr_out_b;
    logic [1:0] ring_s [D];
    logic [1:0] ring_b [DB];

    assign sr_out_s = ring_s[D-1];
    assign sr_out_b = ring_b[DB-1];

    always @(posedge clk) begin
        if (ring_clr) begin
            for (int i = 0; i < D; i++) ring_s[i] <= 2'd0;
            for (int i = 0; i < DB; i++) ring_b[i] <= 2'd0;
        end else begin
            ring_s[0] <= sr_in_s;
            for (int i = 1; i < D; i++) ring_s[i] <= ring_s[i-1];
            ring_b[0] <= sr_in_b;
            for (int i = 1; i < DB; i++) ring_b[i] <= ring_b[i-1];
        end
    end

    snake_body_tracer #(
        .WIDTH(2), .DEPTH(D), .GRID_W(18), .GRID_H(13), .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_S)
    ) dut (
        .clk(clk), .rst(rst), .sr_out(sr_out_s), .sr_in(sr_in_s), .bus(bs)
    );

    snake_body_tracer #(
        .WIDTH(2), .DEPTH(DB), .GRID_W(18), .GRID_H(13), .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_B)
    ) dut_big (
        .clk(clk), .rst(rst), .sr_out(sr_out_b), .sr_in(sr_in_b), .bus(bb)
    );

    task automatic do_push(input logic [1:0] d);
        int n;
        @(negedge clk);
        bs.push_valid = 1'b1;
        bs.push_dir   = d;
        #1;
        n = 0;
        while (!bs.push_ready && n < 4*D) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bs.push_valid = 1'b0;
        bs.push_dir   = 2'd0;
        n = 0;
        @(negedge clk);
        while (bs.busy && n < 4*D) begin @(negedge clk); n++; end
        if (bs.busy) begin
            checks++; failures++;
            $display("FAIL push_complete: busy still %0b after %0d cycles, required 0", bs.busy, n);
        end
    endtask

    task automatic do_trace(input logic [4:0] hx, input logic [3:0] hy, input logic [3:0] len,
                            input logic [4:0] qx, input logic [3:0] qy, output int lat);
        int n;
        @(negedge clk);
        bs.trace_valid = 1'b1;
        bs.head_x = hx; bs.head_y = hy; bs.length = len; bs.query_x = qx; bs.query_y = qy;
        #1;
        n = 0;
        while (!bs.trace_ready && n < 4*D) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bs.trace_valid = 1'b0;
        bs.head_x = 5'd9; bs.head_y = 4'd9; bs.length = 4'd3; bs.query_x = 5'd1; bs.query_y = 4'd1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bs.done && lat < 4*D + 20);
        if (!bs.done) begin
            checks++; failures++;
            $display("FAIL trace_done_timeout: done=%0b after %0d cycles, required 1", bs.done, lat);
        end
    endtask

    task automatic test_reset();
        bs.push_valid = 1'b1; bs.push_dir = 2'd3; bs.trace_valid = 1'b1;
        bs.head_x = '0; bs.head_y = '0; bs.length = 4'd2; bs.query_x = '0; bs.query_y = '0;
        bb.push_valid = 1'b0; bb.push_dir = '0; bb.trace_valid = 1'b0;
        bb.head_x = '0; bb.head_y = '0; bb.length = '0; bb.query_x = '0; bb.query_y = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bs.push_ready !== 1'b0) begin failures++; $display("FAIL rst_push_ready: got %0b required 0", bs.push_ready); end
        checks++; if (bs.trace_ready !== 1'b0) begin failures++; $display("FAIL rst_trace_ready: got %0b required 0", bs.trace_ready); end
        checks++; if ({bs.busy, bs.done, bs.hit} !== 3'b000) begin failures++; $display("FAIL rst_flags: busy/done/hit got %b required 000", {bs.busy, bs.done, bs.hit}); end
        checks++; if ({bs.hit_index, bs.tail_x, bs.tail_y} !== '0) begin failures++; $display("FAIL rst_results: idx=%0d tail=(%0d,%0d) required zeros", bs.hit_index, bs.tail_x, bs.tail_y); end
        checks++; if (dut.phase !== '0) begin failures++; $display("FAIL rst_phase: got %0d required 0", dut.phase); end
        bs.push_valid = 1'b0; bs.trace_valid = 1'b0;
        ring_clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 3*D; i++) begin
            @(negedge clk);
            if (sr_in_s !== sr_out_s || bs.busy !== 1'b0 || bs.done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL idle_recirculate: %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_clamp();
        int lat;
        do_trace(5'd5, 4'd5, 4'd12, 5'd4, 4'd5, lat);
        checks++; if ({bs.tail_x, bs.tail_y} !== {5'd16, 4'd5}) begin failures++; $display("FAIL clamp_tail: got (%0d,%0d) required (16,5)", bs.tail_x, bs.tail_y); end
        checks++; if (bs.hit !== 1'b1 || bs.hit_index !== 4'd1) begin failures++; $display("FAIL clamp_hit: got %0b/%0d required 1/1", bs.hit, bs.hit_index); end
    endtask

    task automatic test_len1();
        int lat;
        do_trace(5'd2, 4'd3, 4'd1, 5'd2, 4'd3, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL len1_latency: got %0d required 1", lat); end
        checks++; if ({bs.tail_x, bs.tail_y, bs.hit, bs.hit_index} !== {5'd2, 4'd3, 1'b0, 4'd0}) begin failures++; $display("FAIL len1_result: tail=(%0d,%0d) hit=%0b idx=%0d required (2,3) 0 0", bs.tail_x, bs.tail_y, bs.hit, bs.hit_index); end
        do_trace(5'd7, 4'd8, 4'd0, 5'd0, 4'd0, lat);
        checks++; if (lat != 1 || {bs.tail_x, bs.tail_y} !== {5'd7, 4'd8}) begin failures++; $display("FAIL len0_result: lat=%0d tail=(%0d,%0d) required 1 (7,8)", lat, bs.tail_x, bs.tail_y); end
    endtask

    task automatic test_body();
        int lat;
        do_push(2'd0); do_push(2'd0); do_push(2'd1);
        do_trace(5'd5, 4'd5, 4'd4, 5'd3, 4'd4, lat);
        checks++; if (bs.hit !== 1'b1 || bs.hit_index !== 4'd3) begin failures++; $display("FAIL body_hit: got %0b/%0d required 1/3", bs.hit, bs.hit_index); end
        checks++; if ({bs.tail_x, bs.tail_y} !== {5'd3, 4'd4}) begin failures++; $display("FAIL body_tail: got (%0d,%0d) required (3,4)", bs.tail_x, bs.tail_y); end
        checks++; if (lat < 4 || lat > D + 4) begin failures++; $display("FAIL body_latency: got %0d required 4..%0d", lat, D + 4); end
        do_trace(5'd5, 4'd5, 4'd4, 5'd5, 4'd5, lat);
        checks++; if (bs.hit !== 1'b0 || bs.hit_index !== 4'd0) begin failures++; $display("FAIL head_not_hit: got %0b/%0d required 0/0", bs.hit, bs.hit_index); end
        do_trace(5'd5, 4'd5, 4'd4, 5'd9, 4'd9, lat);
        checks++; if (bs.hit !== 1'b0 || {bs.tail_x, bs.tail_y} !== {5'd3, 4'd4}) begin failures++; $display("FAIL miss_query: hit=%0b tail=(%0d,%0d) required 0 (3,4)", bs.hit, bs.tail_x, bs.tail_y); end
    endtask

    task automatic test_wrap();
        int lat;
        do_push(2'd2);
        do_trace(5'd17, 4'd0, 4'd2, 5'd0, 4'd0, lat);
        checks++; if ({bs.tail_x, bs.tail_y} !== {5'd0, 4'd0}) begin failures++; $display("FAIL wrap_tail: got (%0d,%0d) required (0,0)", bs.tail_x, bs.tail_y); end
        checks++; if (bs.hit !== 1'b1 || bs.hit_index !== 4'd1) begin failures++; $display("FAIL wrap_hit: got %0b/%0d required 1/1", bs.hit, bs.hit_index); end
    endtask

    task automatic test_priority();
        int n;
        @(negedge clk);
        bs.push_valid = 1'b1; bs.push_dir = 2'd3;
        bs.trace_valid = 1'b1; bs.head_x = 5'd5; bs.head_y = 4'd5; bs.length = 4'd2; bs.query_x = 5'd5; bs.query_y = 4'd6;
        #1;
        checks++; if (bs.push_ready !== 1'b1 || bs.trace_ready !== 1'b0) begin failures++; $display("FAIL prio_ready: push=%0b trace=%0b required 1/0", bs.push_ready, bs.trace_ready); end
        @(posedge clk); #1;
        bs.push_valid = 1'b0;
        n = 0;
        while (!bs.trace_ready && n < 4*D) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bs.trace_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bs.done && n < 4*D);
        checks++; if (bs.done !== 1'b1 || {bs.tail_x, bs.tail_y} !== {5'd5, 4'd6} || bs.hit_index !== 4'd1) begin failures++; $display("FAIL prio_trace: done=%0b tail=(%0d,%0d) idx=%0d required 1 (5,6) 1", bs.done, bs.tail_x, bs.tail_y, bs.hit_index); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        bs.trace_valid = 1'b1; bs.head_x = 5'd5; bs.head_y = 4'd5; bs.length = 4'd8; bs.query_x = 5'd5; bs.query_y = 4'd6;
        #1;
        n = 0;
        while (!bs.trace_ready && n < 4*D) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bs.trace_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bs.hit && n < 4*D);
        checks++; if (bs.hit !== 1'b1 || bs.busy !== 1'b1) begin failures++; $display("FAIL mid_trace_state: hit=%0b busy=%0b required 1/1", bs.hit, bs.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bs.busy !== 1'b0 || bs.hit !== 1'b0 || bs.hit_index !== 4'd0) begin failures++; $display("FAIL mid_rst_outputs: busy=%0b hit=%0b idx=%0d required 0", bs.busy, bs.hit, bs.hit_index); end
        checks++; if (dut.phase !== '0 || sr_in_s !== sr_out_s) begin failures++; $display("FAIL mid_rst_ring: phase=%0d sr_in=%0d sr_out=%0d required 0 and equal", dut.phase, sr_in_s, sr_out_s); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_depth();
        int n;
        @(negedge clk);
        bb.push_valid = 1'b1; bb.push_dir = 2'd1;
        #1;
        checks++; if (bb.push_ready !== 1'b1) begin failures++; $display("FAIL big_push_ready: got %0b required 1", bb.push_ready); end
        @(posedge clk); #1;
        bb.push_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bb.busy && n < DB + 8);
        bb.trace_valid = 1'b1; bb.head_x = 5'd0; bb.head_y = 4'd0; bb.length = 8'd2; bb.query_x = 5'd0; bb.query_y = 4'd12;
        #1;
        @(posedge clk); #1;
        bb.trace_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bb.done && n < DB + 8);
        checks++; if (bb.done !== 1'b1 || {bb.tail_x, bb.tail_y} !== {5'd0, 4'd12}) begin failures++; $display("FAIL big_trace_tail: done=%0b tail=(%0d,%0d) required 1 (0,12)", bb.done, bb.tail_x, bb.tail_y); end
        checks++; if (bb.hit !== 1'b1 || bb.hit_index !== 8'd1) begin failures++; $display("FAIL big_trace_hit: got %0b/%0d required 1/1", bb.hit, bb.hit_index); end
        @(negedge clk);
        bb.trace_valid = 1'b1; bb.head_x = 5'd3; bb.head_y = 4'd4; bb.length = 8'd0;
        @(posedge clk); #1;
        bb.trace_valid = 1'b0;
        @(negedge clk);
        checks++; if (bb.done !== 1'b1 || {bb.tail_x, bb.tail_y} !== {5'd3, 4'd4} || bb.hit !== 1'b0) begin failures++; $display("FAIL big_len0: done=%0b tail=(%0d,%0d) hit=%0b required 1 (3,4) 0", bb.done, bb.tail_x, bb.tail_y, bb.hit); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_clamp();
        test_len1();
        test_body();
        test_wrap();
        test_priority();
        test_reset_mid();
        test_default_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snake_body_tracer.md
Name: snake_body_tracer

Overview:
- Reader/writer end of the snake body shift register, which is a free-running, unresettable DEPTH-stage ring of WIDTH-bit directions.
- Owns the ring's input: recirculates `sr_out` back to `sr_in` and tracks the ring phase.
- Inserts new head directions on request.
- Walks the body on request to reconstruct segment coordinates, flag a collision with a query tile and report the tail tile.
- Sits between game logic (move/collision checks) and the shiftreg instance.

Parameters:
- WIDTH, 2, direction code width (must be 2).
- DEPTH, 234, ring length; equals the maximum snake length.
- GRID_W, 18, grid columns.
- GRID_H, 13, grid rows.
- X_W, 5, x coordinate width.
- Y_W, 4, y coordinate width.
- LEN_W, 8, length width; equals $clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- sr_out  in  WIDTH  direction from ring last stage
- sr_in  out  WIDTH  direction into ring first stage
- push_valid  in  1  request to insert new head direction
- push_dir  in  WIDTH  direction of the new head move
- push_ready  out  1  push accepted this cycle
- trace_valid  in  1  request a body trace
- trace_ready  out  1  trace accepted this cycle
- head_x  in  X_W  head column, sampled at trace accept
- head_y  in  Y_W  head row, sampled at trace accept
- length  in  LEN_W  segment count including head, sampled at trace accept
- query_x  in  X_W  tile to test, sampled at trace accept
- query_y  in  Y_W  tile to test, sampled at trace accept
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse; trace results valid
- hit  out  1  query matched a body segment (index 1..length-1)
- hit_index  out  LEN_W  first matching index; 0 when no hit
- tail_x  out  X_W  last segment column
- tail_y  out  Y_W  last segment row

Behaviour:
- Direction codes: 0 RIGHT (+x), 1 DOWN (+y), 2 LEFT (-x), 3 UP (-y). d_k is the move from segment k to segment k-1. seg_k = seg_{k-1} - delta(d_k), with wrap mod GRID_W / GRID_H (x=0 minus 1 -> GRID_W-1, etc.).
- phase: free-running counter 0..DEPTH-1, +1 per cycle, wraps DEPTH-1 -> 0. A value driven on sr_in at phase p reappears on sr_out at phase p, DEPTH cycles later.
- head_phase: phase at which d_1 (the head-adjacent direction) appears on sr_out.
- sr_in = sr_out every cycle except the single push write cycle, including during rst.
- Reset: phase=0, head_phase=0, state=IDLE. busy, done, hit, hit_index, tail_x, tail_y all 0. push_ready=trace_ready=0 while rst is high. Ring contents are not cleared; length governs validity.
- State IDLE:
  - push_ready = push_valid.
  - trace_ready = trace_valid & !push_valid (push has priority; a refused trace must stay valid).
  - Push accept: latch push_dir -> PUSH_WAIT.
  - Trace accept: latch inputs; length 0 treated as 1, length > DEPTH clamped to DEPTH.
  - Trace with length==1: -> DONE with tail=head, no wait.
  - Otherwise -> TRACE_WAIT.
- State PUSH_WAIT:
  - At the cycle with phase == (head_phase-1) mod DEPTH: sr_in = latched dir, head_phase <= that phase -> IDLE.
  - Wait is 1..DEPTH cycles.
- State TRACE_WAIT: when phase == head_phase, enter TRACE, consuming sr_out in that same cycle as d_1.
- State TRACE:
  - Each cycle k = 1..L-1: pos <= pos - delta(sr_out). If the new pos equals query and hit==0, set hit and hit_index=k.
  - After k = L-1: tail <= pos -> DONE.
- State DONE: done=1 for one cycle -> IDLE.
  - hit, hit_index, tail hold until the next trace accept, which clears hit/hit_index.
- Latency, trace accept to done: length==1 -> 1 cycle. Otherwise the wait (≤ DEPTH cycles), plus L-1 cycles in TRACE, plus the DONE cycle.
- Head (index 0) is never counted as a hit.
- Inputs are sampled only at accept; later changes are ignored.
- rst mid-operation: abandons immediately to reset values. A push not yet written is lost.

Decomposition:
- snake_pkg:
  - dir_t enum (RIGHT/DOWN/LEFT/UP).
  - GRID_W, GRID_H, DEPTH defaults.
  - State enum.
- Sub-module snake_step: combinational wrap-around reverse step (pos, dir -> prev pos). Shared with the head-movement logic.

Test Plan:
Bench models the ring as a DEPTH-stage delay line; use DEPTH=8 plus one default-DEPTH run.
- Reset, then idle for 3*DEPTH cycles -> sr_in always equals sr_out; busy=0, done=0.
- Push RIGHT, RIGHT, DOWN from reset (DEPTH=8); trace head (5,5), length 4, query (3,4) -> segments (5,5),(5,4),(4,4),(3,4); done with hit=1, hit_index=3, tail=(3,4).
- Same body, query (5,5) (head) -> hit=0, hit_index=0; query (9,9) -> hit=0.
- Wrap: push LEFT; trace head (GRID_W-1,0), length 2 -> tail=(0,0).
- Trace with length 1, head (2,3) -> done 1 cycle after accept, tail=(2,3), hit=0.
- push_valid and trace_valid in the same cycle -> push accepted, trace held; trace then sees the new head direction as d_1.
- Assert rst during TRACE -> next cycle busy=0, hit=0, phase=0, sr_in==sr_out.
